fetch_ctrl: RTL and testbench

- Drives the PC control interface (incPC, loadFromI, I) and consumes the PC output AR. It is the control end of the PC register.
- Reads the instruction memory at AR, holds the returned word in an output register, and hands it to the decoder with a valid/ready handshake.
- Redirects the PC on branch requests from the SM core.
- Sits in the Scheduler between the PC, the instruction memory and the decoder.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_ctrl_if.sv | 31 +++
 rtl/fetch_ctrl.sv | 81 ++++++++
 tb/tb_fetch_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and FSM state type for the instruction fetch controller.
package fetch_ctrl_pkg;

    localparam int INSTMEM_ADDR_WIDTH = 16;
    localparam int INST_WIDTH         = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        VALID,
        REDIR
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the PC control, instruction memory, decoder and redirect signals around fetch_ctrl.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic                          en;
    logic [INSTMEM_ADDR_WIDTH-1:0] AR;
    logic                          incPC;
    logic                          loadFromI;
    logic [INSTMEM_ADDR_WIDTH-1:0] I;
    logic                          mem_rd;
    logic [INSTMEM_ADDR_WIDTH-1:0] mem_addr;
    logic [INST_WIDTH-1:0]         mem_rdata;
    logic [INST_WIDTH-1:0]         inst;
    logic                          inst_valid;
    logic                          inst_ready;
    logic                          branch_valid;
    logic [INSTMEM_ADDR_WIDTH-1:0] branch_target;
    logic                          busy;

    // master is the fetch controller; slave is the PC / memory / decoder environment
    modport master (
        input  en, AR, mem_rdata, inst_ready, branch_valid, branch_target,
        output incPC, loadFromI, I, mem_rd, mem_addr, inst, inst_valid, busy
    );

    modport slave (
        output en, AR, mem_rdata, inst_ready, branch_valid, branch_target,
        input  incPC, loadFromI, I, mem_rd, mem_addr, inst, inst_valid, busy
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch FSM: reads memory at the PC, buffers the word for the decoder, handles redirects.
// Optional macro FETCH_CTRL_PREFETCH_EN: issue the next read on the handshake cycle (2-cycle rate).
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    fetch_state_t                  state;
    logic [INST_WIDTH-1:0]         inst_q;
    logic                          inst_valid_q;
    logic [INSTMEM_ADDR_WIDTH-1:0] target_q;

    logic hs;
    logic take_branch;
    logic prefetch;

    assign hs          = inst_valid_q & bus.inst_ready;
    // An idle, disabled block ignores redirects; everywhere else a branch wins
    assign take_branch = bus.branch_valid & ((state != IDLE) | bus.en);

`ifdef FETCH_CTRL_PREFETCH_EN
    assign prefetch = (state == VALID) & hs & bus.en & ~bus.branch_valid;
`else
    assign prefetch = 1'b0;
`endif

    assign bus.mem_rd     = (state == FETCH) | prefetch;
    assign bus.mem_addr   = bus.mem_rd ? bus.AR : '0;
    assign bus.incPC      = (state == WAIT) & ~take_branch;
    assign bus.loadFromI  = (state == REDIR);
    assign bus.I          = target_q;
    assign bus.inst       = inst_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            target_q     <= '0;
        end else if (take_branch) begin
            // Drop whatever is buffered or in flight; REDIR loads the PC next cycle
            state        <= REDIR;
            target_q     <= bus.branch_target;
            inst_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) state <= FETCH;
                end
                FETCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    inst_q       <= bus.mem_rdata;
                    inst_valid_q <= 1'b1;
                    state        <= VALID;
                end
                VALID: begin
                    if (hs) begin
                        inst_valid_q <= 1'b0;
                        if (prefetch)    state <= WAIT;
                        else if (bus.en) state <= FETCH;
                        else             state <= IDLE;
                    end
                end
                REDIR: begin
                    state <= FETCH;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register and synchronous instruction memory.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

`ifdef FETCH_CTRL_PREFETCH_EN
    localparam int RATE = 2;
`else
    localparam int RATE = 3;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   pulses;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
    logic [INST_WIDTH-1:0] mem [0:255];

    fetch_ctrl_if bus();

    fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model: increments or loads I on the pulses from the controller
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             bus.AR <= '0;
        else if (bus.incPC)     bus.AR <= bus.AR + 16'd1;
        else if (bus.loadFromI) bus.AR <= bus.I;
    end

    // Synchronous memory; garbage when no read was issued
    always_ff @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        else            bus.mem_rdata <= 32'hBAD0_0BAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0001 + 32'(i) * 32'h100;
        mem[8'h80] = 32'hDEAD_BEEF;

        reset             = 1'b0;
        bus.en            = 1'b0;
        bus.inst_ready    = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = '0;

        cyc(); #1;
        chk("rst_busy",   32'(bus.busy), 0);
        chk("rst_valid",  32'(bus.inst_valid), 0);
        chk("rst_inst",   bus.inst, 0);
        chk("rst_rd",     32'(bus.mem_rd), 0);
        chk("rst_addr",   32'(bus.mem_addr), 0);
        chk("rst_inc",    32'(bus.incPC), 0);
        chk("rst_load",   32'(bus.loadFromI), 0);
        chk("rst_I",      32'(bus.I), 0);

        // First fetch from PC 0
        cyc(); reset = 1'b1;
        cyc(); bus.en = 1'b1; #1;
        chk("idle_busy",  32'(bus.busy), 0);
        cyc(); #1;
        chk("c1_rd",      32'(bus.mem_rd), 1);
        chk("c1_addr",    32'(bus.mem_addr), 0);
        chk("c1_inc",     32'(bus.incPC), 0);
        cyc(); #1;
        chk("c2_inc",     32'(bus.incPC), 1);
        chk("c2_rd",      32'(bus.mem_rd), 0);
        chk("c2_valid",   32'(bus.inst_valid), 0);
        cyc(); #1;
        chk("c3_valid",   32'(bus.inst_valid), 1);
        chk("c3_inst",    bus.inst, 32'hA000_0001);
        chk("c3_AR",      32'(bus.AR), 1);

        // Decoder stalls for 10 cycles
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            chk("stall_inst", bus.inst, 32'hA000_0001);
            chk("stall_rd",   32'(bus.mem_rd), 0);
            chk("stall_inc",  32'(bus.incPC), 0);
            chk("stall_AR",   32'(bus.AR), 1);
        end

        // Stream with inst_ready held high
        cyc(); bus.inst_ready = 1'b1; #1;
        chk("hs0_valid", 32'(bus.inst_valid), 1);
        chk("hs0_rd",    32'(bus.mem_rd), (RATE == 2) ? 1 : 0);
        chk("hs0_addr",  32'(bus.mem_addr), (RATE == 2) ? 1 : 0);
        for (int n = 1; n <= 3; n++) begin
            pulses = 0;
            for (int j = 1; j <= RATE; j++) begin
                cyc();
                if (j == RATE && n == 3) bus.en = 1'b0;
                #1;
                pulses += int'(bus.incPC);
                if (j == RATE) begin
                    exp_rd   = (RATE == 2 && n < 3) ? 1 : 0;
                    exp_addr = (exp_rd == 1) ? 32'(n + 1) : 0;
                    chk("str_valid",  32'(bus.inst_valid), 1);
                    chk("str_inst",   bus.inst, 32'hA000_0001 + 32'(n) * 32'h100);
                    chk("str_AR",     32'(bus.AR), 32'(n + 1));
                    chk("str_pulses", 32'(pulses), 1);
                end else begin
                    exp_rd   = (RATE == 3 && j == 1) ? 1 : 0;
                    exp_addr = (exp_rd == 1) ? 32'(n) : 0;
                    chk("str_gap_valid", 32'(bus.inst_valid), 0);
                end
                chk("str_rd",   32'(bus.mem_rd), exp_rd);
                chk("str_addr", 32'(bus.mem_addr), exp_addr);
            end
        end
        cyc(); #1;
        chk("en0_busy",  32'(bus.busy), 0);
        chk("en0_valid", 32'(bus.inst_valid), 0);
        bus.inst_ready = 1'b0;

        // Branch during WAIT
        cyc(); bus.en = 1'b1;
        cyc(); #1;
        chk("b_fetch_addr", 32'(bus.mem_addr), 4);
        cyc(); bus.branch_valid = 1'b1; bus.branch_target = 16'h0040; #1;
        chk("b_wait_inc", 32'(bus.incPC), 0);
        cyc(); bus.branch_valid = 1'b0; #1;
        chk("b_redir_load",  32'(bus.loadFromI), 1);
        chk("b_redir_I",     32'(bus.I), 32'h40);
        chk("b_redir_valid", 32'(bus.inst_valid), 0);
        chk("b_redir_inc",   32'(bus.incPC), 0);
        cyc(); #1;
        chk("b_fetch_rd",    32'(bus.mem_rd), 1);
        chk("b_fetch2_addr", 32'(bus.mem_addr), 32'h40);
        chk("b_fetch_valid", 32'(bus.inst_valid), 0);
        cyc(); #1;
        chk("b_wait2_inc", 32'(bus.incPC), 1);
        cyc(); #1;
        chk("b_valid",   32'(bus.inst_valid), 1);
        chk("b_inst",    bus.inst, 32'hA000_4001);
        chk("b_AR",      32'(bus.AR), 32'h41);

        // Branch in the same cycle as a handshake
        bus.inst_ready = 1'b1; bus.branch_valid = 1'b1; bus.branch_target = 16'h0080; #1;
        chk("bh_rd", 32'(bus.mem_rd), 0);
        cyc(); bus.branch_valid = 1'b0; bus.inst_ready = 1'b0; #1;
        chk("bh_load",  32'(bus.loadFromI), 1);
        chk("bh_I",     32'(bus.I), 32'h80);
        chk("bh_valid", 32'(bus.inst_valid), 0);
        cyc(); #1;
        chk("bh_addr",  32'(bus.mem_addr), 32'h80);
        cyc();
        cyc(); #1;
        chk("bh_inst",  bus.inst, 32'hDEAD_BEEF);

        // Asynchronous reset while holding a valid word
        reset = 1'b0; #1;
        chk("ar_valid", 32'(bus.inst_valid), 0);
        chk("ar_inst",  bus.inst, 0);
        chk("ar_busy",  32'(bus.busy), 0);
        chk("ar_I",     32'(bus.I), 0);

        // Branch while idle and disabled is ignored
        cyc(); reset = 1'b1; bus.en = 1'b0;
        bus.branch_valid = 1'b1; bus.branch_target = 16'h0010;
        cyc(); bus.branch_valid = 1'b0; #1;
        chk("idle_br_busy", 32'(bus.busy), 0);
        chk("idle_br_load", 32'(bus.loadFromI), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
